// File: rtl/cpu_run_monitor.sv
// Run controller for the cpu core: sequences its reset, counts RUN cycles, detects jump-to-self halt, checks result.
// Latency: done rises one cycle after halt (CHECK) or on the timeout edge; no backpressure, start is ignored outside IDLE/DONE.
module cpu_run_monitor #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int RESET_CYCLES   = 4,
    parameter int HALT_REPEAT    = 3,
    parameter int TIMEOUT_CYCLES = 100,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [DATA_WIDTH-1:0]    expected_result,
    input  logic [DATA_WIDTH-1:0]    result,
    input  logic [ADDRESS_WIDTH-1:0] pcw,
    output logic                     cpu_rst,
    output logic                     done,
    output logic                     pass,
    output logic                     timeout,
    output logic [CNT_WIDTH-1:0]     cycle_count,
    output logic [ADDRESS_WIDTH-1:0] halt_pc
);

    localparam int RST_W = $clog2(RESET_CYCLES + 1);
    localparam int REP_W = $clog2(HALT_REPEAT + 1);

    localparam logic [RST_W-1:0]     RST_LAST    = RST_W'(RESET_CYCLES - 1);
    localparam logic [REP_W-1:0]     REP_HALT    = REP_W'(HALT_REPEAT);
    localparam logic [CNT_WIDTH-1:0] CNT_TIMEOUT = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_CHECK,
        S_DONE
    } state_t;

    state_t                   state;
    logic [RST_W-1:0]         rst_cnt;
    logic [REP_W-1:0]         rep_cnt;
    logic [ADDRESS_WIDTH-1:0] prev_pc;

    logic [CNT_WIDTH-1:0]     cnt_next;
    logic [REP_W-1:0]         rep_next;
    logic                     first_run;
    logic                     halt_hit;
    logic                     timeout_hit;

    // cycle_count is cleared on start and never wraps to zero, so zero marks the first RUN cycle
    always_comb begin
        first_run   = (cycle_count == '0);
        cnt_next    = (cycle_count == CNT_MAX) ? cycle_count : cycle_count + CNT_WIDTH'(1);
        rep_next    = '0;
        if (!first_run && (pcw == prev_pc)) begin
            rep_next = rep_cnt + REP_W'(1);
        end
        halt_hit    = !first_run && (rep_next == REP_HALT);
        timeout_hit = !halt_hit && (cnt_next == CNT_TIMEOUT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cpu_rst     <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            halt_pc     <= '0;
            rep_cnt     <= '0;
            rst_cnt     <= '0;
            prev_pc     <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_RESET;
                        cpu_rst     <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        timeout     <= 1'b0;
                        cycle_count <= '0;
                        halt_pc     <= '0;
                        rep_cnt     <= '0;
                        rst_cnt     <= '0;
                    end
                end
                S_RESET: begin
                    if (rst_cnt == RST_LAST) begin
                        state   <= S_RUN;
                        cpu_rst <= 1'b0;
                    end else begin
                        rst_cnt <= rst_cnt + RST_W'(1);
                    end
                end
                S_RUN: begin
                    cycle_count <= cnt_next;
                    prev_pc     <= pcw;
                    rep_cnt     <= rep_next;
                    if (halt_hit) begin
                        halt_pc <= pcw;
                        state   <= S_CHECK;
                    end else if (timeout_hit) begin
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                        done    <= 1'b1;
                        cpu_rst <= 1'b1;
                        state   <= S_DONE;
                    end
                end
                S_CHECK: begin
                    pass    <= (result == expected_result);
                    done    <= 1'b1;
                    cpu_rst <= 1'b1;
                    state   <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Scoreboard bench for cpu_run_monitor: a program-level model predicts each run's outcome, a monitor checks it when done rises.
module tb_cpu_run_monitor;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RC = 4;
    localparam int HR = 3;
    localparam int TO = 100;
    localparam int CW = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic [DW-1:0] expected_result;
    logic [DW-1:0] result;
    logic [AW-1:0] pcw;
    logic          cpu_rst;
    logic          done;
    logic          pass;
    logic          timeout;
    logic [CW-1:0] cycle_count;
    logic [AW-1:0] halt_pc;

    cpu_run_monitor #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .RESET_CYCLES  (RC),
        .HALT_REPEAT   (HR),
        .TIMEOUT_CYCLES(TO),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .expected_result(expected_result),
        .result         (result),
        .pcw            (pcw),
        .cpu_rst        (cpu_rst),
        .done           (done),
        .pass           (pass),
        .timeout        (timeout),
        .cycle_count    (cycle_count),
        .halt_pc        (halt_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        int            edge_n;
        logic          pass;
        logic          timeout;
        logic [CW-1:0] cnt;
        logic [AW-1:0] hpc;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    logic          done_q = 1'b0;
    int            checks = 0;
    int            errors = 0;
    int            edge_cnt = 0;
    logic [AW-1:0] seq[0:255];
    int            seq_len = 1;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // program counter presented in RUN cycle m (1-based); the program parks on its last address
    function automatic logic [AW-1:0] pc_at(input int m);
        if (m <= seq_len) return seq[m-1];
        return seq[seq_len-1];
    endfunction

    // halt = first cycle whose pc equals the HR preceding pcs, if it happens within the timeout
    function automatic void model(output bit halted, output int hcyc, output logic [AW-1:0] hpc);
        bit same;
        halted = 1'b0;
        hcyc   = TO;
        hpc    = '0;
        for (int k = HR + 1; k <= TO; k++) begin
            if (!halted) begin
                same = 1'b1;
                for (int j = k - HR; j < k; j++) begin
                    if (pc_at(j) != pc_at(k)) same = 1'b0;
                end
                if (same) begin
                    halted = 1'b1;
                    hcyc   = k;
                    hpc    = pc_at(k);
                end
            end
        end
    endfunction

    always @(negedge clk) begin
        if (done && !done_q) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done rose with no run outstanding (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                chk("done_edge", 64'(edge_cnt), 64'(mon_e.edge_n));
                chk("pass", pass, mon_e.pass);
                chk("timeout", timeout, mon_e.timeout);
                chk("cycle_count", cycle_count, mon_e.cnt);
                chk("halt_pc", halt_pc, mon_e.hpc);
                chk("cpu_rst_done", cpu_rst, 1'b1);
            end
        end
        done_q <= done;
    end

    task automatic set_halt_seq();
        seq[0] = 32'h0; seq[1] = 32'h4; seq[2] = 32'h8; seq[3] = 32'hC;
        seq_len = 4;
    endtask

    task automatic run_prog(input logic [DW-1:0] res, input logic [DW-1:0] exp_v,
                            input int start_at, input int abort_at);
        bit            halted;
        int            hcyc;
        int            e0;
        int            n_run;
        logic [AW-1:0] hpc;
        exp_t          e;
        model(halted, hcyc, hpc);
        result          = res;
        expected_result = exp_v;
        start           = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0    = edge_cnt;
        chk("flags_cleared", {done, pass, timeout}, 3'b000);
        chk("count_cleared", cycle_count, 0);
        chk("halt_pc_cleared", halt_pc, 0);
        if (abort_at == 0) begin
            e.edge_n  = halted ? e0 + RC + hcyc + 1 : e0 + RC + TO;
            e.pass    = halted && (res == exp_v);
            e.timeout = !halted;
            e.cnt     = CW'(hcyc);
            e.hpc     = hpc;
            sb.push_back(e);
        end
        for (int i = 0; i < RC; i++) begin
            chk("cpu_rst_held", cpu_rst, 1'b1);
            @(negedge clk);
        end
        n_run = halted ? hcyc + 1 : TO;
        for (int k = 1; k <= n_run; k++) begin
            if (k == 1) chk("cpu_rst_released", cpu_rst, 1'b0);
            if (k <= 3) chk("run_count", cycle_count, 64'(k - 1));
            if (abort_at != 0 && k == abort_at + 1) begin
                chk("abort_count", cycle_count, 64'(abort_at));
                rst = 1'b0;
                #1;
                chk("abort_cpu_rst", cpu_rst, 1'b1);
                chk("abort_flags", {done, pass, timeout}, 3'b000);
                chk("abort_count_clr", cycle_count, 0);
                chk("abort_halt_pc", halt_pc, 0);
                @(negedge clk);
                rst   = 1'b1;
                start = 1'b0;
                @(negedge clk);
                return;
            end
            pcw   = pc_at(k);
            start = (k == start_at);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst             = 1'b1;
        start           = 1'b0;
        result          = '0;
        expected_result = '0;
        pcw             = '0;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_cpu_rst", cpu_rst, 1'b1);
        chk("reset_flags", {done, pass, timeout}, 3'b000);
        chk("reset_count", cycle_count, 0);
        chk("reset_halt_pc", halt_pc, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_cpu_rst", cpu_rst, 1'b1);

        set_halt_seq();
        run_prog(32'h2A, 32'h2A, 0, 0);
        run_prog(32'h29, 32'h2A, 0, 0);

        // two extra repeats of 0x10, then strictly advancing: no halt, timeout
        for (int i = 0; i < 3; i++) seq[i] = 32'h10;
        for (int i = 3; i < 200; i++) seq[i] = AW'(32'h10 + 4 * (i - 2));
        seq_len = 200;
        run_prog(32'h5, 32'h5, 0, 0);

        for (int i = 0; i < 200; i++) seq[i] = AW'(32'h100 + 4 * i);
        seq_len = 200;
        run_prog(32'h1, 32'h1, 0, 20);

        set_halt_seq();
        run_prog(32'h2A, 32'h2A, 0, 0);
        run_prog(32'h2A, 32'h2A, 6, 0);

        // halt lands exactly on the timeout cycle
        for (int i = 0; i < 97; i++) seq[i] = AW'(4 * (i + 1));
        seq_len = 97;
        run_prog(32'h7, 32'h7, 0, 0);

        repeat (12) begin
            logic [AW-1:0] base;
            logic [DW-1:0] r;
            base    = AW'($urandom);
            seq_len = int'($urandom_range(1, 150));
            for (int i = 0; i < seq_len; i++) seq[i] = base + AW'(4 * $urandom_range(0, 3));
            r = DW'($urandom);
            run_prog(r, ($urandom_range(0, 1) == 1) ? r : r ^ (DW'(1) << $urandom_range(0, DW - 1)),
                     int'($urandom_range(0, 8)), 0);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
